// File: rtl/pass_entry.sv
// Debounced pass-digit entry: synchronizes a bouncy enter button, emits one strobe per
// accepted press with the latched digit, and tracks the position within a 4-digit sequence.
module pass_entry #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_num,
    input  logic       btn_enter_n,
    input  logic       clear,
    output logic [3:0] passnum,
    output logic       p_enter,
    output logic [1:0] digit_idx,
    output logic       seq_done
);
    // state    | meaning
    // IDLE     | waiting for a synchronized press
    // DEBOUNCE | press seen, counting stable pressed cycles
    // FIRE     | single strobe cycle, digit latched
    // HOLD     | waiting for a stable release before rearming
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] FIRE     = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    localparam logic [15:0] DB_LIM     = 16'(DB_CYCLES);
    localparam logic [15:0] DB_LIM_M1  = 16'(DB_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] cnt;
    logic        sync_q1;
    logic        sync_q2;
    logic        btn_s;
    logic        fire_go;

    // Flops reset to the released (high) level so a held button after reset is a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= btn_enter_n;
            sync_q2 <= sync_q1;
        end
    end

    assign btn_s   = ~sync_q2;
    assign fire_go = (state == DEBOUNCE) && btn_s && (cnt == DB_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DEBOUNCE;
                        cnt   <= 16'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                    end else if (cnt == DB_LIM) begin
                        state <= FIRE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FIRE: begin
                    state <= HOLD;
                    cnt   <= 16'd0;
                end
                HOLD: begin
                    // Leave on the edge where the released count would reach DB_CYCLES.
                    if (btn_s) begin
                        cnt <= 16'd0;
                    end else if (cnt == DB_LIM_M1) begin
                        state <= IDLE;
                        cnt   <= 16'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 16'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            passnum  <= 4'd0;
            p_enter  <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            p_enter  <= fire_go;
            seq_done <= fire_go && (digit_idx == 2'd3);
            if (fire_go) begin
                passnum <= sw_num;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx <= 2'd0;
        end else if (clear) begin
            digit_idx <= 2'd0;
        end else if (state == FIRE) begin
            digit_idx <= digit_idx + 2'd1;
        end
    end

endmodule

// File: tb/tb_pass_entry.sv
// Directed bench for pass_entry: press latency, bounce rejection, digit sequencing,
// release debounce, clear priority and mid-press reset.
module tb_pass_entry;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_num;
    logic       btn_enter_n;
    logic       clear;
    logic [3:0] passnum;
    logic       p_enter;
    logic [1:0] digit_idx;
    logic       seq_done;

    int n_cmp = 0;
    int n_err = 0;

    pass_entry #(.DB_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_num      (sw_num),
        .btn_enter_n (btn_enter_n),
        .clear       (clear),
        .passnum     (passnum),
        .p_enter     (p_enter),
        .digit_idx   (digit_idx),
        .seq_done    (seq_done)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press and hold: returns edges until strobe (edge k is tick 1), latched digit,
    // seq_done seen with the strobe, and any extra strobes while held and released.
    task automatic press(input logic [3:0] d, input bit do_clear, output int lat,
                         output logic [3:0] pn, output logic sd, output int extra);
        bit found;
        found = 1'b0;
        lat   = 0;
        pn    = 4'hx;
        sd    = 1'bx;
        extra = 0;
        sw_num      = d;
        btn_enter_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (p_enter) begin
                found = 1'b1;
                lat   = i;
                pn    = passnum;
                sd    = seq_done;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL press_timeout: no p_enter within 30 edges for digit %0d", d);
        end
        clear  = do_clear;
        sw_num = ~d;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (p_enter) extra++;
        end
        btn_enter_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (p_enter) extra++;
        end
        n_cmp++;
        if (passnum !== d) begin
            n_err++;
            $display("FAIL passnum_stable: got %0d expected %0d", passnum, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw_num = 4'd0;
        btn_enter_n = 1'b1;
        clear = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({passnum, p_enter, digit_idx, seq_done} !== 8'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0", {passnum, p_enter, digit_idx, seq_done});
        end
        n_cmp++;
        if (dut.state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected 0", dut.state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_press();
        int lat, extra;
        logic [3:0] pn;
        logic sd;
        press(4'd3, 1'b0, lat, pn, sd, extra);
        n_cmp++;
        if (lat !== 7) begin n_err++; $display("FAIL clean_latency: got %0d expected 7", lat); end
        n_cmp++;
        if (pn !== 4'd3) begin n_err++; $display("FAIL clean_passnum: got %0d expected 3", pn); end
        n_cmp++;
        if (sd !== 1'b0) begin n_err++; $display("FAIL clean_seq_done: got %b expected 0", sd); end
        n_cmp++;
        if (extra !== 0) begin n_err++; $display("FAIL clean_extra_pulses: got %0d expected 0", extra); end
        n_cmp++;
        if (digit_idx !== 2'd1) begin n_err++; $display("FAIL clean_digit_idx: got %0d expected 1", digit_idx); end
    endtask

    task automatic test_bounce();
        int pulses;
        logic [4:0] pat;
        pulses = 0;
        pat = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            btn_enter_n = pat[4-i];
            tick();
            if (p_enter) pulses++;
        end
        btn_enter_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p_enter) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d expected 0", pulses); end
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL bounce_state: got %0d expected 0", dut.state); end
        n_cmp++;
        if (digit_idx !== 2'd1) begin n_err++; $display("FAIL bounce_digit_idx: got %0d expected 1", digit_idx); end
    endtask

    task automatic test_sequence();
        logic [3:0] digits [4];
        int lat, extra;
        logic [3:0] pn;
        logic sd;
        digits[0] = 4'd3; digits[1] = 4'd1; digits[2] = 4'd5; digits[3] = 4'd3;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (digit_idx !== 2'd0) begin n_err++; $display("FAIL seq_clear: got %0d expected 0", digit_idx); end
        for (int i = 0; i < 4; i++) begin
            press(digits[i], 1'b0, lat, pn, sd, extra);
            n_cmp++;
            if (pn !== digits[i]) begin n_err++; $display("FAIL seq_passnum[%0d]: got %0d expected %0d", i, pn, digits[i]); end
            n_cmp++;
            if (sd !== (i == 3)) begin n_err++; $display("FAIL seq_done[%0d]: got %b expected %b", i, sd, (i == 3)); end
            n_cmp++;
            if (extra !== 0) begin n_err++; $display("FAIL seq_extra[%0d]: got %0d expected 0", i, extra); end
        end
        n_cmp++;
        if (digit_idx !== 2'd0) begin n_err++; $display("FAIL seq_wrap: got %0d expected 0", digit_idx); end
        n_cmp++;
        if (seq_done !== 1'b0) begin n_err++; $display("FAIL seq_done_low: got %b expected 0", seq_done); end
    endtask

    task automatic test_hold_bounce();
        int pulses;
        bit found;
        pulses = 0;
        found = 1'b0;
        sw_num = 4'd7;
        btn_enter_n = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (p_enter) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL hold_press_timeout: no p_enter within 30 edges"); end
        for (int i = 0; i < 6; i++) tick();
        btn_enter_n = 1'b1; tick(); if (p_enter) pulses++;
        tick(); if (p_enter) pulses++;
        btn_enter_n = 1'b0; tick(); if (p_enter) pulses++;
        btn_enter_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (p_enter) pulses++;
        end
        n_cmp++;
        if (dut.state !== 2'd3) begin n_err++; $display("FAIL hold_early_state: got %0d expected 3", dut.state); end
        tick();
        n_cmp++;
        if (dut.state !== 2'd0) begin n_err++; $display("FAIL hold_idle_state: got %0d expected 0", dut.state); end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL hold_extra_pulses: got %0d expected 0", pulses); end
    endtask

    task automatic test_clear();
        int lat, extra;
        logic [3:0] pn;
        logic sd;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        press(4'd9, 1'b0, lat, pn, sd, extra);
        press(4'd6, 1'b1, lat, pn, sd, extra);
        n_cmp++;
        if (pn !== 4'd6) begin n_err++; $display("FAIL clear_passnum: got %0d expected 6", pn); end
        n_cmp++;
        if (lat !== 7) begin n_err++; $display("FAIL clear_latency: got %0d expected 7", lat); end
        n_cmp++;
        if (digit_idx !== 2'd0) begin n_err++; $display("FAIL clear_digit_idx: got %0d expected 0", digit_idx); end
    endtask

    task automatic test_reset_mid();
        int lat, extra;
        logic [3:0] pn;
        logic sd;
        bit found;
        press(4'd5, 1'b0, lat, pn, sd, extra);
        sw_num = 4'd12;
        btn_enter_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (dut.cnt !== 16'd2) begin n_err++; $display("FAIL mid_cnt_setup: got %0d expected 2", dut.cnt); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({passnum, p_enter, digit_idx, seq_done} !== 8'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b expected 0", {passnum, p_enter, digit_idx, seq_done});
        end
        tick();
        tick();
        rst = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30 && !found; i++) begin
            tick();
            if (p_enter) begin
                found = 1'b1;
                lat = i;
            end
        end
        n_cmp++;
        if (lat !== 7) begin n_err++; $display("FAIL mid_reset_latency: got %0d expected 7", lat); end
        n_cmp++;
        if (passnum !== 4'd12) begin n_err++; $display("FAIL mid_reset_passnum: got %0d expected 12", passnum); end
        btn_enter_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_hold_bounce();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
